pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic inter-stage pipeline register for the pipelined CPU; the generic successor to the fixed per-stage registers (ID/EX, EX/MEM, MEM/WB).
- Carries a data payload (ALU result, store data, PC+4, ...) and a control payload (MemRead/MemWrite/RegWrite/...) through DEPTH register slots.
- Adds what the fixed registers lack: per-slot valid bits, ready/valid stall back-pressure, bubble collapse, synchronous flush, and an occupancy count.

Parameters:
- DATA_W, 101, data payload width in bits; holds no control meaning.
- CTRL_W, 5, control payload width in bits; forced to 0 whenever its slot is invalid.
- DEPTH, 1, number of register slots, 1..8.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all slots, e.g. a branch mispredict.
- in_valid  in  1  upstream offers a word this cycle.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  the head slot holds a live word.
- out_ready  in  1  downstream consumes the head this cycle; low means stall.
- out_data  out  DATA_W  head data; value is don't-care when out_valid=0.
- out_ctrl  out  CTRL_W  head control; equals 0 when out_valid=0.
- occupancy  out  $clog2(DEPTH+1)  number of valid slots.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high.
- Reset:
  - On a rising edge with reset=1, every slot's valid, data and ctrl clear to 0.
  - Consequently out_valid=0, out_ctrl=0, out_data=0 and occupancy=0.
  - in_ready=0 while reset=1.
  - reset has priority over flush, load and advance.
- Slot structure:
  - Slot 0 is the input side; slot DEPTH-1 is the head.
- Advance rule:
  - The head advances when out_ready=1 or when the head is invalid.
  - Slot i (i<DEPTH-1) advances when slot i+1 advances or slot i+1 is invalid (bubble collapse).
- Input side:
  - in_ready = !reset && !flush && (slot 0 advances || slot 0 invalid).
  - in_ready may depend combinationally on out_ready.
  - An accepted word (in_valid && in_ready) loads slot 0 with valid=1.
  - If slot 0 advances and nothing is accepted, slot 0 becomes invalid and its ctrl clears to 0.
- Hold: a non-advancing slot holds data, ctrl and valid unchanged.
- Latency:
  - A word accepted at edge N is visible at the output after edge N+DEPTH-1, provided nothing stalls.
  - Maximum throughput is 1 word/cycle.
- DEPTH=1 case:
  - in_ready = !reset && !flush && (!out_valid || out_ready).
  - Behaves as a stall-capable EX/MEM register.
- Flush:
  - At the edge, all valid bits and all ctrl fields clear; data fields keep their values.
  - The in_data offered in the flush cycle is dropped (in_ready=0).
  - If out_valid && out_ready in the flush cycle, that head word counts as consumed (downstream transfer completes).
  - occupancy is 0 on the following cycle.
- Simultaneous load and unload when full: the slot chain advances and slot 0 loads, so occupancy stays unchanged.
- occupancy:
  - Registered; updates by +1, -1 or 0 per cycle.
  - Never exceeds DEPTH and never underflows; an assertion checks this.
- Don't-care input: in_valid=0 with garbage in_ctrl never leaks into out_ctrl.

Decomposition:
- Shared package cpu_pipe_pkg:
  - Stage payload widths: IDEX_DATA_W, EXMEM_DATA_W=101 (32+32+5+32), MEMWB_DATA_W.
  - Control widths: EXMEM_CTRL_W=5 (MemRead, MemWrite, MemtoReg[1:0], RegWrite).
  - Packing-order constants used by every stage instance.
- Sub-module pipe_slot: one valid/data/ctrl slot with load, hold and clear. pipe_stage_reg instantiates it DEPTH times via generate and adds the advance chain and occupancy counter.

Test Plan:
- Reset mid-stream:
  - Stimulus: DEPTH=2, two words loaded, then reset=1 for 1 cycle.
  - Required response: next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=0 during the reset cycle.
- Streaming:
  - Stimulus: DEPTH=3, out_ready=1, words data=0x10..0x14, ctrl=5'b10011, one per cycle.
  - Required response: first out_valid 2 cycles after first accept, in order, no gaps, occupancy steady at 3.
- Stall and fill:
  - Stimulus: DEPTH=2, out_ready=0, in_valid=1 with data 0xA, 0xB, 0xC.
  - Required response: 0xA and 0xB accepted, in_ready=0 on 0xC, occupancy=2, out_data=0xA held.
  - Then out_ready=1 for one cycle: out_data=0xB, 0xC accepted in the same cycle.
- Bubble collapse:
  - Stimulus: DEPTH=3, accept 0x1, idle 1 cycle, accept 0x2, head stalled.
  - Required response: after 3 cycles slots hold 0x1 and 0x2 adjacently, occupancy=2, in_ready=1.
- Flush with simultaneous transfer:
  - Stimulus: DEPTH=2 full (0x7 at head, 0x8 behind), out_ready=1, flush=1, in_valid=1 with 0x9.
  - Required response: 0x7 counted consumed, 0x8 and 0x9 dropped, next cycle out_valid=0, out_ctrl=0, occupancy=0.
- Control gating:
  - Stimulus: DEPTH=1, in_valid=0 with in_ctrl=5'b11111 for 5 cycles.
  - Required response: out_ctrl stays 0 and out_valid stays 0 throughout.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared widths, packing order and control layout for the inter-stage pipeline registers.
package cpu_pipe_pkg;

  // ID/EX: pc4, rs1 value, rs2 value, imm, rs1/rs2/rd indices
  localparam int unsigned IDEX_DATA_W  = 32 + 32 + 32 + 32 + 5 + 5 + 5;
  // EX/MEM: alu result, store data, rd index, pc4
  localparam int unsigned EXMEM_DATA_W = 32 + 32 + 5 + 32;
  // MEM/WB: load data, alu result, rd index, pc4
  localparam int unsigned MEMWB_DATA_W = 32 + 32 + 5 + 32;

  localparam int unsigned IDEX_CTRL_W  = 9;
  localparam int unsigned EXMEM_CTRL_W = 5;
  localparam int unsigned MEMWB_CTRL_W = 3;

  localparam int unsigned EXMEM_ALU_LSB   = 69;
  localparam int unsigned EXMEM_STORE_LSB = 37;
  localparam int unsigned EXMEM_RD_LSB    = 32;
  localparam int unsigned EXMEM_PC4_LSB   = 0;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic    mem_read;
    logic    mem_write;
    wb_sel_e mem_to_reg;
    logic    reg_write;
  } exmem_ctrl_t;

  function automatic logic [EXMEM_DATA_W-1:0] pack_exmem(
    input logic [31:0] alu_result,
    input logic [31:0] store_data,
    input logic [4:0]  rd,
    input logic [31:0] pc4
  );
    return {alu_result, store_data, rd, pc4};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register slot: valid/data/ctrl with load, hold, flush and reset.
module pipe_slot
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = EXMEM_DATA_W,
  parameter int unsigned CTRL_W = EXMEM_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              en,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d,  data_q;
  logic [CTRL_W-1:0] ctrl_d,  ctrl_q;

  // Data only moves with a live word; ctrl is forced to zero whenever the slot is empty.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (en) begin
      valid_d = d_valid;
      ctrl_d  = d_valid ? d_ctrl : '0;
      if (d_valid) data_d = d_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign q_valid = valid_q;
  assign q_data  = data_q;
  assign q_ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic DEPTH-slot inter-stage register with ready/valid stall, bubble collapse, flush and occupancy.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = EXMEM_DATA_W,
  parameter int unsigned CTRL_W = EXMEM_CTRL_W,
  parameter int unsigned DEPTH  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  slot_valid;
  logic [DATA_W-1:0] slot_data [DEPTH];
  logic [CTRL_W-1:0] slot_ctrl [DEPTH];
  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  slot_en;
  logic [DEPTH-1:0]  src_valid;
  logic [DATA_W-1:0] src_data [DEPTH];
  logic [CTRL_W-1:0] src_ctrl [DEPTH];
  logic              full_above;
  logic              accept;
  logic              unload;
  logic [OCC_W-1:0]  occ_d, occ_q;

  // Slot i advances unless out_ready is low and every slot above it (and the head) is full;
  // written as a forward scan instead of the recursive chain to avoid a self-referencing vector.
  always_comb begin
    adv        = '0;
    full_above = slot_valid[DEPTH-1];
    for (int unsigned k = 0; k < DEPTH; k++) begin
      adv[DEPTH-1-k] = out_ready || !full_above;
      full_above     = full_above && slot_valid[DEPTH-1-k];
    end
  end

  assign in_ready = !reset && !flush && (adv[0] || !slot_valid[0]);
  assign accept   = in_valid && in_ready;
  assign unload   = slot_valid[DEPTH-1] && out_ready;

  always_comb begin
    slot_en      = '0;
    src_valid    = '0;
    slot_en[0]   = accept || adv[0];
    src_valid[0] = accept;
    src_data[0]  = in_data;
    src_ctrl[0]  = in_ctrl;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      slot_en[k]   = adv[k-1];
      src_valid[k] = slot_valid[k-1];
      src_data[k]  = slot_data[k-1];
      src_ctrl[k]  = slot_ctrl[k-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    pipe_slot #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W)
    ) u_slot (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .en     (slot_en[g]),
      .d_valid(src_valid[g]),
      .d_data (src_data[g]),
      .d_ctrl (src_ctrl[g]),
      .q_valid(slot_valid[g]),
      .q_data (slot_data[g]),
      .q_ctrl (slot_ctrl[g])
    );
  end

  // A head word taken during a flush still leaves, so the count simply drops to zero.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !unload) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!accept && unload) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
      assert (occ_q <= OCC_W'(DEPTH));
      assert (!(unload && !accept && occ_q == '0));
    end
  end

  assign out_valid = slot_valid[DEPTH-1];
  assign out_data  = slot_data[DEPTH-1];
  assign out_ctrl  = slot_ctrl[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg at DEPTH 1, 2 and 3 with shared stimulus and a per-test scoreboard.
module tb_pipe_stage_reg;

  localparam int DW = 101;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          d1_in_ready, d2_in_ready, d3_in_ready;
  logic          d1_out_valid, d2_out_valid, d3_out_valid;
  logic [DW-1:0] d1_out_data, d2_out_data, d3_out_data;
  logic [CW-1:0] d1_out_ctrl, d2_out_ctrl, d3_out_ctrl;
  logic [0:0]    d1_occ;
  logic [1:0]    d2_occ, d3_occ;

  int            sel;
  logic          c_in_ready, c_out_valid;
  logic [DW-1:0] c_out_data;
  logic [CW-1:0] c_out_ctrl;
  int            c_occ;

  int   total = 0;
  int   bad   = 0;
  logic pre_ir;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic          rst, fl, iv;
    logic [DW-1:0] id;
    logic [CW-1:0] ic;
    logic          ordy;
    logic          e_ir, e_ov, chk_od;
    logic [DW-1:0] e_od;
    logic [CW-1:0] e_oc;
    int            e_occ;
  } vec_t;
  vec_t tbl[15];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d1_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(d1_out_valid), .out_ready(out_ready),
    .out_data(d1_out_data), .out_ctrl(d1_out_ctrl), .occupancy(d1_occ));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_data(d2_out_data), .out_ctrl(d2_out_ctrl), .occupancy(d2_occ));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d3_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(d3_out_valid), .out_ready(out_ready),
    .out_data(d3_out_data), .out_ctrl(d3_out_ctrl), .occupancy(d3_occ));

  always_comb begin
    c_in_ready  = d1_in_ready;
    c_out_valid = d1_out_valid;
    c_out_data  = d1_out_data;
    c_out_ctrl  = d1_out_ctrl;
    c_occ       = int'(d1_occ);
    if (sel == 2) begin
      c_in_ready  = d2_in_ready;
      c_out_valid = d2_out_valid;
      c_out_data  = d2_out_data;
      c_out_ctrl  = d2_out_ctrl;
      c_occ       = int'(d2_occ);
    end else if (sel == 3) begin
      c_in_ready  = d3_in_ready;
      c_out_valid = d3_out_valid;
      c_out_data  = d3_out_data;
      c_out_ctrl  = d3_out_ctrl;
      c_occ       = int'(d3_occ);
    end
  end

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (depth sel %0d): actual=%0h required=%0h", name, sel, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic rst, input logic fl, input logic iv, input logic [DW-1:0] id,
                              input logic [CW-1:0] ic, input logic ordy, input logic e_ir,
                              input logic e_ov, input logic chk_od, input logic [DW-1:0] e_od,
                              input logic [CW-1:0] e_oc, input int e_occ);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.chk_od = chk_od; v.e_od = e_od; v.e_oc = e_oc; v.e_occ = e_occ;
    return v;
  endfunction

  // One clock: drive, sample pre-edge (in_ready, head transfer), then sample post-edge.
  task automatic step(input logic rst, input logic fl, input logic iv, input logic [DW-1:0] id,
                      input logic [CW-1:0] ic, input logic ordy);
    logic acc, unl;
    exp_t w;
    reset = rst; flush = fl; in_valid = iv; in_data = id; in_ctrl = ic; out_ready = ordy;
    #2;
    pre_ir = c_in_ready;
    if (rst || fl) chk("in_ready_blocked", c_in_ready, 0);
    if (!rst && !c_out_valid) chk("ctrl_gate", c_out_ctrl, 0);
    acc = iv && c_in_ready;
    unl = !rst && c_out_valid && ordy;
    if (unl) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: actual=%0h required=none", c_out_data);
      end else begin
        w = sbq.pop_front();
        chk("sb_data", c_out_data, w.data);
        chk("sb_ctrl", c_out_ctrl, w.ctrl);
      end
    end
    @(posedge clk);
    #1;
    if (rst || fl) sbq.delete();
    else if (acc) sbq.push_back({id, ic});
    chk("occupancy", c_occ, sbq.size());
  endtask

  task automatic do_reset(input int s);
    sel = s;
    step(1, 0, 0, '0, '0, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    sel = 1;
    @(posedge clk);
    #1;

    // DEPTH=1 vector table
    tbl[0]  = mk(1, 0, 1, 'h55, 5'h1f, 1,  0, 0, 1, 'h0, 5'h00, 0);
    tbl[1]  = mk(0, 0, 1, 'hA,  5'h13, 0,  1, 1, 1, 'hA, 5'h13, 1);
    tbl[2]  = mk(0, 0, 1, 'hB,  5'h01, 0,  0, 1, 1, 'hA, 5'h13, 1);
    tbl[3]  = mk(0, 0, 1, 'hB,  5'h01, 1,  1, 1, 1, 'hB, 5'h01, 1);
    tbl[4]  = mk(0, 0, 0, 'hC,  5'h1f, 1,  1, 0, 0, 'h0, 5'h00, 0);
    for (int i = 5; i < 10; i++)
      tbl[i] = mk(0, 0, 0, 'hEE, 5'h1f, 0, 1, 0, 0, 'h0, 5'h00, 0);
    tbl[10] = mk(0, 0, 1, 'hD,  5'h04, 0,  1, 1, 1, 'hD, 5'h04, 1);
    tbl[11] = mk(0, 1, 1, 'hE,  5'h1f, 1,  0, 0, 1, 'hD, 5'h00, 0);
    tbl[12] = mk(0, 0, 1, 'hF,  5'h02, 1,  1, 1, 1, 'hF, 5'h02, 1);
    tbl[13] = mk(1, 0, 1, 'h1,  5'h01, 1,  0, 0, 1, 'h0, 5'h00, 0);
    tbl[14] = mk(0, 0, 0, 'h0,  5'h1f, 1,  1, 0, 1, 'h0, 5'h00, 0);

    sel = 1;
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ic, tbl[i].ordy);
      chk($sformatf("t%0d_in_ready", i), pre_ir, tbl[i].e_ir);
      chk($sformatf("t%0d_out_valid", i), c_out_valid, tbl[i].e_ov);
      if (tbl[i].chk_od) chk($sformatf("t%0d_out_data", i), c_out_data, tbl[i].e_od);
      chk($sformatf("t%0d_out_ctrl", i), c_out_ctrl, tbl[i].e_oc);
      chk($sformatf("t%0d_occ", i), c_occ, tbl[i].e_occ);
    end

    // Reset mid-stream, DEPTH=2
    do_reset(2);
    step(0, 0, 1, 'h1, 5'h03, 0);
    step(0, 0, 1, 'h2, 5'h05, 0);
    chk("rst_full_occ", c_occ, 2);
    step(1, 0, 1, 'h3, 5'h07, 0);
    chk("rst_ov", c_out_valid, 0);
    chk("rst_oc", c_out_ctrl, 0);
    chk("rst_od", c_out_data, 0);

    // Streaming, DEPTH=3
    do_reset(3);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, DW'('h10 + k), 5'b10011, 1);
      chk($sformatf("stream_ov%0d", k), c_out_valid, k >= 2);
      if (k >= 2) chk($sformatf("stream_occ%0d", k), c_occ, 3);
    end
    chk("stream_head", c_out_data, 'h12);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, '0, 5'h1f, 1);
      chk($sformatf("drain_ov%0d", k), c_out_valid, k < 2);
    end

    // Stall and fill, DEPTH=2
    do_reset(2);
    step(0, 0, 1, 'hA, 5'h01, 0);
    chk("fill_ir_a", pre_ir, 1);
    step(0, 0, 1, 'hB, 5'h02, 0);
    chk("fill_ir_b", pre_ir, 1);
    step(0, 0, 1, 'hC, 5'h03, 0);
    chk("fill_ir_c", pre_ir, 0);
    chk("fill_occ", c_occ, 2);
    chk("fill_head", c_out_data, 'hA);
    step(0, 0, 1, 'hC, 5'h03, 1);
    chk("fill_ir_c2", pre_ir, 1);
    chk("fill_head2", c_out_data, 'hB);
    chk("fill_occ2", c_occ, 2);
    step(0, 0, 0, '0, '0, 1);
    step(0, 0, 0, '0, '0, 1);
    chk("fill_empty", c_out_valid, 0);

    // Bubble collapse, DEPTH=3
    do_reset(3);
    step(0, 0, 1, 'h1, 5'h01, 0);
    step(0, 0, 0, '0, 5'h1f, 0);
    step(0, 0, 1, 'h2, 5'h02, 0);
    step(0, 0, 0, '0, 5'h1f, 0);
    chk("bub_head", c_out_data, 'h1);
    chk("bub_occ", c_occ, 2);
    chk("bub_ir", c_in_ready, 1);
    step(0, 0, 0, '0, '0, 1);
    chk("bub_adjacent_ov", c_out_valid, 1);
    chk("bub_adjacent_od", c_out_data, 'h2);
    step(0, 0, 0, '0, '0, 1);
    chk("bub_empty", c_out_valid, 0);

    // Flush with simultaneous head transfer, DEPTH=2
    do_reset(2);
    step(0, 0, 1, 'h7, 5'h11, 0);
    step(0, 0, 1, 'h8, 5'h12, 0);
    chk("fl_full", c_occ, 2);
    step(0, 1, 1, 'h9, 5'h13, 1);
    chk("fl_ov", c_out_valid, 0);
    chk("fl_oc", c_out_ctrl, 0);
    step(0, 0, 0, '0, '0, 1);
    chk("fl_dropped", c_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
